// File: rtl/timer_apb_pkg.sv
// Shared definitions for the timer APB requester: FSM encoding, default
// bus widths and the timer register map.
package timer_apb_pkg;

  // APB master FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Default bus widths (12-bit timer register space, 32-bit data)
  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 32;

  // Timer register map
  localparam logic [11:0] TCR_ADDR   = 12'h000;
  localparam logic [11:0] TDR0_ADDR  = 12'h004;
  localparam logic [11:0] TDR1_ADDR  = 12'h008;
  localparam logic [11:0] TCMP0_ADDR = 12'h00C;
  localparam logic [11:0] TCMP1_ADDR = 12'h010;
  localparam logic [11:0] TIER_ADDR  = 12'h014;
  localparam logic [11:0] TISR_ADDR  = 12'h018;
  localparam logic [11:0] THCSR_ADDR = 12'h01C;

endpackage

// File: rtl/apb_rsp_buf.sv
// Single-entry response register with a valid/ready output handshake.
// A load always wins; otherwise the entry clears when the consumer takes it.
module apb_rsp_buf
  import timer_apb_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_rdata,
  input  logic              load_err,
  input  logic              load_timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  logic              valid_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              timeout_r;

  // Fill on load, clear on a completed handshake, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else if (load) begin
      valid_r   <= 1'b1;
      rdata_r   <= load_rdata;
      err_r     <= load_err;
      timeout_r <= load_timeout;
    end else if (valid_r && rsp_ready) begin
      valid_r   <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      valid_r   <= valid_r;
      rdata_r   <= rdata_r;
      err_r     <= err_r;
      timeout_r <= timeout_r;
    end
  end

  assign rsp_valid   = valid_r;
  assign rsp_rdata   = rdata_r;
  assign rsp_err     = err_r;
  assign rsp_timeout = timeout_r;

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 initiator: converts a valid/ready command stream into one APB
// transfer at a time, with a PREADY timeout and a one-entry response buffer.
module apb_cmd_master
  import timer_apb_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [ADDR_W-1:0]   apb_paddr,
  output logic [DATA_W-1:0]   apb_pwdata,
  output logic [DATA_W/8-1:0] apb_pstrb,
  input  logic [DATA_W-1:0]   apb_prdata,
  input  logic                apb_pready,
  input  logic                apb_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
  // Counter value seen on the last ACCESS cycle allowed before abort
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e          state_r, next_state_s;
  logic                psel_r, psel_s;
  logic                penable_r, penable_s;
  logic [TO_CNT_W-1:0] to_cnt_r, to_cnt_s;
  logic                pwrite_r;
  logic [ADDR_W-1:0]   paddr_r;
  logic [DATA_W-1:0]   pwdata_r;
  logic [STRB_W-1:0]   pstrb_r;
  logic                accept_s;
  logic                load_s;
  logic [DATA_W-1:0]   load_rdata_s;
  logic                load_err_s;
  logic                load_timeout_s;

  // A new command may start only from IDLE with no undrained response
  assign cmd_ready = (state_r == IDLE) && (!rsp_valid || rsp_ready);
  assign accept_s  = cmd_valid && cmd_ready;

  // Next-state, next APB control values and response load
  always_comb begin
    next_state_s   = state_r;
    psel_s         = psel_r;
    penable_s      = penable_r;
    to_cnt_s       = to_cnt_r;
    load_s         = 1'b0;
    load_rdata_s   = {DATA_W{1'b0}};
    load_err_s     = 1'b0;
    load_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SETUP;
          psel_s       = 1'b1;
          penable_s    = 1'b0;
        end else begin
          psel_s    = 1'b0;
          penable_s = 1'b0;
        end
      end
      SETUP: begin
        next_state_s = ACCESS;
        penable_s    = 1'b1;
        to_cnt_s     = {TO_CNT_W{1'b0}};
      end
      ACCESS: begin
        if (apb_pready) begin
          // Completion has priority over a coincident timeout
          next_state_s = IDLE;
          psel_s       = 1'b0;
          penable_s    = 1'b0;
          load_s       = 1'b1;
          load_err_s   = apb_pslverr;
          if (pwrite_r) begin
            load_rdata_s = {DATA_W{1'b0}};
          end else begin
            load_rdata_s = apb_prdata;
          end
        end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
          next_state_s   = IDLE;
          psel_s         = 1'b0;
          penable_s      = 1'b0;
          load_s         = 1'b1;
          load_err_s     = 1'b1;
          load_timeout_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TO_CNT_W'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        psel_s       = 1'b0;
        penable_s    = 1'b0;
      end
    endcase
  end

  // FSM state, APB control and timeout counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      to_cnt_r  <= {TO_CNT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      psel_r    <= psel_s;
      penable_r <= penable_s;
      to_cnt_r  <= to_cnt_s;
    end
  end

  // APB address/data path: captured only on command acceptance, then held
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwrite_r <= 1'b0;
      paddr_r  <= {ADDR_W{1'b0}};
      pwdata_r <= {DATA_W{1'b0}};
      pstrb_r  <= {STRB_W{1'b0}};
    end else if (accept_s) begin
      pwrite_r <= cmd_write;
      paddr_r  <= cmd_addr;
      pwdata_r <= cmd_wdata;
      pstrb_r  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
    end else begin
      pwrite_r <= pwrite_r;
      paddr_r  <= paddr_r;
      pwdata_r <= pwdata_r;
      pstrb_r  <= pstrb_r;
    end
  end

  assign apb_psel    = psel_r;
  assign apb_penable = penable_r;
  assign apb_pwrite  = pwrite_r;
  assign apb_paddr   = paddr_r;
  assign apb_pwdata  = pwdata_r;
  assign apb_pstrb   = pstrb_r;

  apb_rsp_buf #(
    .DATA_W (DATA_W)
  ) u_rsp_buf (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .load         (load_s),
    .load_rdata   (load_rdata_s),
    .load_err     (load_err_s),
    .load_timeout (load_timeout_s),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_timeout  (rsp_timeout)
  );

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: behavioural APB slave with
// programmable wait states / error / hang, and a response scoreboard.
module tb_apb_cmd_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = 12'h000;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_strb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [11:0] apb_paddr;
  logic [31:0] apb_pwdata;
  logic [3:0]  apb_pstrb;
  logic [31:0] apb_prdata = 32'h0;
  logic        apb_pready = 1'b0;
  logic        apb_pslverr = 1'b0;

  // slave model controls
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic        slv_hang = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_cnt = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_master #(
    .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(16), .TO_CNT_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural APB slave, updated away from the active edge
  always @(negedge sys_clk) begin
    if (apb_psel && apb_penable && !slv_hang && slv_cnt == slv_wait) begin
      apb_pready  = 1'b1;
      apb_pslverr = slv_err;
      apb_prdata  = apb_pwrite ? 32'h0BAD_0BAD : slv_rdata;
    end else if (apb_psel && apb_penable) begin
      apb_pready  = 1'b0;
      apb_pslverr = 1'b0;
      apb_prdata  = 32'hFFFF_FFFF;
      slv_cnt     = slv_cnt + 1;
    end else begin
      apb_pready  = 1'b0;
      apb_pslverr = 1'b0;
      apb_prdata  = 32'h0;
      slv_cnt     = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one command, wait (bounded) for acceptance, push its expectation
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] e_rdata,
                       input logic e_err, input logic e_to);
    exp_t e;
    bit ok;
    @(negedge sys_clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    check_eq("cmd_accept", 32'(ok), 32'd1);
    e.rdata = e_rdata; e.err = e_err; e.to = e_to;
    sb_q.push_back(e);
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
    // later changes must not disturb the transfer
    cmd_addr = 12'hFFF; cmd_wdata = 32'h5555_AAAA; cmd_write = ~wr; cmd_strb = 4'h5;
  endtask

  task automatic cmp_rsp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_rdata"}, rsp_rdata, e.rdata);
      check_eq({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      check_eq({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
    end
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, drain it
  task automatic get_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check_eq({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      cmp_rsp(tag);
      rsp_ready = 1'b1;
      @(posedge sys_clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    // ---------------- reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check_eq("rst_psel", 32'(apb_psel), 32'd0);
    check_eq("rst_penable", 32'(apb_penable), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_paddr", 32'(apb_paddr), 32'd0);
    check_eq("rst_pstrb", 32'(apb_pstrb), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // ---------------- zero-wait write, cycle-exact timing
    issue(1'b1, 12'h00C, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    check_eq("wr_setup_psel", 32'(apb_psel), 32'd1);
    check_eq("wr_setup_penable", 32'(apb_penable), 32'd0);
    check_eq("wr_pwrite", 32'(apb_pwrite), 32'd1);
    check_eq("wr_paddr", 32'(apb_paddr), 32'h00C);
    check_eq("wr_pwdata", apb_pwdata, 32'hDEAD_BEEF);
    check_eq("wr_pstrb", 32'(apb_pstrb), 32'hF);
    @(posedge sys_clk); #1;
    check_eq("wr_access_penable", 32'(apb_penable), 32'd1);
    check_eq("wr_access_paddr", 32'(apb_paddr), 32'h00C);
    check_eq("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge sys_clk); #1;
    check_eq("wr_done_psel", 32'(apb_psel), 32'd0);
    check_eq("wr_done_rsp_valid", 32'(rsp_valid), 32'd1);
    get_rsp("wr");

    // ---------------- read with 2 wait states
    slv_wait = 2; slv_rdata = 32'h1234_5678;
    issue(1'b0, 12'h004, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    check_eq("rd_pstrb", 32'(apb_pstrb), 32'h0);
    check_eq("rd_pwrite", 32'(apb_pwrite), 32'd0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (apb_penable) n++;
      if (!apb_psel) break;
    end
    check_eq("rd_penable_cycles", 32'(n), 32'd3);
    get_rsp("rd");
    slv_wait = 0;

    // ---------------- slave error on write to TCR
    slv_err = 1'b1;
    issue(1'b1, 12'h000, 32'h0000_0900, 4'hF, 32'h0, 1'b1, 1'b0);
    check_eq("err_pwdata_11_8", 32'(apb_pwdata[11:8]), 32'h9);
    get_rsp("slverr");
    slv_err = 1'b0;

    // ---------------- timeout with pready stuck low
    slv_hang = 1'b1;
    issue(1'b0, 12'h008, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (apb_psel && apb_penable) n++;
      else if (!apb_psel) break;
    end
    check_eq("to_access_cycles", 32'(n), 32'd16);
    check_eq("to_psel_low", 32'(apb_psel), 32'd0);
    get_rsp("timeout");
    slv_hang = 1'b0;
    slv_rdata = 32'hCAFE_0014;
    issue(1'b0, 12'h014, 32'h0, 4'h0, 32'hCAFE_0014, 1'b0, 1'b0);
    get_rsp("after_to");

    // ---------------- response back-pressure
    slv_rdata = 32'hA5A5_0018;
    issue(1'b0, 12'h018, 32'h0, 4'h0, 32'hA5A5_0018, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    check_eq("bp_rsp_seen", 32'(ok), 32'd1);
    cmd_write = 1'b1; cmd_addr = 12'h010; cmd_wdata = 32'h0000_0077; cmd_strb = 4'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_rdata", rsp_rdata, 32'hA5A5_0018);
      check_eq("bp_psel", 32'(apb_psel), 32'd0);
      @(negedge sys_clk);
    end
    cmp_rsp("bp");
    begin
      exp_t e;
      e.rdata = 32'h0; e.err = 1'b0; e.to = 1'b0;
      sb_q.push_back(e);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check_eq("bp_drained", 32'(rsp_valid), 32'd0);
    check_eq("bp_next_psel", 32'(apb_psel), 32'd1);
    check_eq("bp_next_paddr", 32'(apb_paddr), 32'h010);
    check_eq("bp_next_pstrb", 32'(apb_pstrb), 32'h3);
    get_rsp("bp_next");

    // ---------------- asynchronous reset during ACCESS
    slv_wait = 5;
    issue(1'b0, 12'h01C, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (apb_penable) begin ok = 1'b1; break; end
    end
    check_eq("ar_in_access", 32'(ok), 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_eq("ar_psel", 32'(apb_psel), 32'd0);
    check_eq("ar_penable", 32'(apb_penable), 32'd0);
    check_eq("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    sb_q.delete();
    slv_wait = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check_eq("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge sys_clk);
    check_eq("ar_no_rsp", 32'(rsp_valid), 32'd0);
    slv_rdata = 32'h0BEE_F01C;
    issue(1'b0, 12'h01C, 32'h0, 4'h0, 32'h0BEE_F01C, 1'b0, 1'b0);
    get_rsp("post_reset");
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
